fetch_predict: RTL and testbench

- Instruction fetch stage with a 2-bit dynamic branch predictor.
- It is the producer side of the fetch-to-decode pipeline register: it drives pcC/instC/stateC, and it obeys the stall and fail_predict signals that the register also consumes.
- It holds the PC, reads the instruction ROM, predicts the next PC from a direct-mapped BHT+BTB, and accepts training updates from the execute stage.

---
 rtl/fetch_predict.sv | 113 +++++++++++
 tb/tb_fetch_predict.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict.sv
// Instruction fetch stage: PC register, instruction ROM interface and a
// direct-mapped 2-bit BHT + BTB next-PC predictor trained from execute.
module fetch_predict #(
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [12:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [12:0] pcC,
    output logic [31:0] instC,
    output logic [1:0]  stateC,
    input  logic        stall,
    input  logic        fail_predict,
    input  logic [12:0] redirect_pc,
    input  logic        upd_en,
    input  logic [12:0] upd_pc,
    input  logic        upd_taken,
    input  logic [12:0] upd_target,
    input  logic [1:0]  upd_state
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 11 - IDX_W;

    function automatic logic [1:0] sat_step(input logic [1:0] st, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (st == 2'b11) ? 2'b11 : st + 2'b01;
        end else begin
            res = (st == 2'b00) ? 2'b00 : st - 2'b01;
        end
        return res;
    endfunction

    logic [12:0]      r_pc;
    logic [1:0]       r_bht        [ENTRIES];
    logic [ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0] r_btb_tag    [ENTRIES];
    logic [10:0]      r_btb_target [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_pred_taken;
    logic [12:0]      w_pc_next;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic [1:0]       w_bht_new;
    logic             w_unused_ok;

    assign w_idx        = r_pc[IDX_W+1:2];
    assign w_tag        = r_pc[12:IDX_W+2];
    assign w_hit        = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_pred_taken = w_hit && r_bht[w_idx][1];
    assign w_upd_idx    = upd_pc[IDX_W+1:2];
    assign w_upd_tag    = upd_pc[12:IDX_W+2];
    assign w_bht_new    = sat_step(upd_state, upd_taken);
    // Byte-offset bits of the incoming addresses are architecturally ignored.
    assign w_unused_ok  = ^{redirect_pc[1:0], upd_target[1:0], upd_pc[1:0]};

    assign imem_addr = r_pc;
    assign pcC       = r_pc;
    assign instC     = imem_rdata;
    assign stateC    = r_bht[w_idx];

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        w_pc_next = r_pc + 13'd4;
        if (fail_predict) begin
            w_pc_next = {redirect_pc[12:2], 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = {r_btb_target[w_idx], 2'b00};
        end else begin
            w_pc_next = r_pc + 13'd4;
        end
    end

    // PC register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc <= 13'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Counters and valid bits; the counter is rewritten from the carried state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
            r_btb_valid <= '0;
        end else if (upd_en) begin
            r_bht[w_upd_idx] <= w_bht_new;
            if (upd_taken) begin
                r_btb_valid[w_upd_idx] <= 1'b1;
            end
        end
    end

    // Tag and target payload, qualified by the valid bits so no reset needed.
    always_ff @(posedge CLK) begin
        if (upd_en && upd_taken) begin
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= upd_target[12:2];
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Randomised + directed bench for fetch_predict: a reference model pushes the
// expected fetch outputs into a queue, a monitor pops and compares them.
module tb_fetch_predict;

    localparam int IDX_W = 4;
    localparam int N     = 1 << IDX_W;

    logic        CLK;
    logic        RST;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [12:0] pcC;
    logic [31:0] instC;
    logic [1:0]  stateC;
    logic        stall;
    logic        fail_predict;
    logic [12:0] redirect_pc;
    logic        upd_en;
    logic [12:0] upd_pc;
    logic        upd_taken;
    logic [12:0] upd_target;
    logic [1:0]  upd_state;

    fetch_predict #(.IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pcC(pcC), .instC(instC), .stateC(stateC),
        .stall(stall), .fail_predict(fail_predict), .redirect_pc(redirect_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_state(upd_state)
    );

    function automatic logic [31:0] rom_f(input logic [12:0] a);
        return {a, 19'h5A5A5} ^ (32'(a) * 32'h9E3779B1);
    endfunction

    assign imem_rdata = rom_f(imem_addr);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [12:0] pc;
        logic [1:0]  st;
        logic [31:0] inst;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: plain integers, indexed by arithmetic on the PC.
    int m_pc;
    int m_bht[N];
    bit m_valid[N];
    int m_tag[N];
    int m_tgt[N];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < N; i++) begin
            m_bht[i]   = 1;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic cycle(input bit st, input bit fp, input int rpc, input bit ue,
                         input int upc, input bit ut, input int utgt, input int ust);
        exp_t e;
        int   i, u, nxt;
        bit   hit;
        @(negedge CLK);
        i      = (m_pc / 4) % N;
        e.pc   = 13'(m_pc);
        e.st   = 2'(m_bht[i]);
        e.inst = rom_f(13'(m_pc));
        q.push_back(e);
        stall        = st;
        fail_predict = fp;
        redirect_pc  = 13'(rpc);
        upd_en       = ue;
        upd_pc       = 13'(upc);
        upd_taken    = ut;
        upd_target   = 13'(utgt);
        upd_state    = 2'(ust);
        hit = m_valid[i] && (m_tag[i] == m_pc / (4 * N));
        if (fp)                         nxt = rpc - (rpc % 4);
        else if (st)                    nxt = m_pc;
        else if (hit && m_bht[i] >= 2)  nxt = m_tgt[i];
        else                            nxt = (m_pc + 4) % 8192;
        if (ue) begin
            u = (upc / 4) % N;
            if (ut) begin
                m_bht[u]   = (ust >= 3) ? 3 : ust + 1;
                m_valid[u] = 1'b1;
                m_tag[u]   = upc / (4 * N);
                m_tgt[u]   = utgt - (utgt % 4);
            end else begin
                m_bht[u] = (ust <= 0) ? 0 : ust - 1;
            end
        end
        m_pc = nxt;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic redir(input int pc);
        cycle(1'b0, 1'b1, pc, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic peek(input string nm, input int epc, input int est);
        @(posedge CLK);
        #1;
        check({nm, "_pc"}, 32'(pcC), 32'(epc));
        check({nm, "_state"}, 32'(stateC), 32'(est));
    endtask

    // Monitor: every cycle the DUT presents a fetch; compare it to the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("mon_pc", 32'(pcC), 32'(e.pc));
                check("mon_state", 32'(stateC), 32'(e.st));
                check("mon_inst", instC, e.inst);
                check("mon_imem_addr", 32'(imem_addr), 32'(e.pc));
            end
        end
    end

    initial begin
        RST = 1'b1;
        stall = 1'b1; fail_predict = 1'b0; redirect_pc = 13'd0;
        upd_en = 1'b0; upd_pc = 13'd0; upd_taken = 1'b0; upd_target = 13'd0; upd_state = 2'd0;
        model_reset();
        #22;
        check("reset_pc", 32'(pcC), 32'h0);
        check("reset_state", 32'(stateC), 32'h1);
        @(negedge CLK);
        RST = 1'b0;

        // Free run from reset, all the way around the 13-bit space.
        idle();
        peek("free1", 'h004, 1);
        for (int k = 1; k < 2048; k++) idle();
        peek("wrap", 'h000, 1);

        // Stall at 0x020 while training 0x010 taken -> 0x040.
        redir('h020);
        peek("redir020", 'h020, 1);
        cycle(1'b1, 1'b0, 0, 1'b1, 'h010, 1'b1, 'h040, 1);
        peek("stall1", 'h020, 1);
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
        peek("stall2", 'h020, 1);
        redir('h010);
        peek("trained_state", 'h010, 2);
        idle();
        peek("pred_taken", 'h040, 1);
        cycle(1'b0, 1'b0, 0, 1'b1, 'h010, 1'b0, 0, 2);
        peek("untrain_step", 'h044, 1);
        redir('h010);
        peek("untrained_state", 'h010, 1);
        idle();
        peek("not_pred", 'h014, 1);

        // Saturation at both ends.
        cycle(1'b0, 1'b0, 0, 1'b1, 'h010, 1'b1, 'h040, 3);
        peek("sat_step", 'h018, 1);
        redir('h010);
        peek("sat_hi", 'h010, 3);
        cycle(1'b0, 1'b0, 0, 1'b1, 'h018, 1'b0, 0, 0);
        peek("sat_pred", 'h040, 1);
        redir('h018);
        peek("sat_lo", 'h018, 0);

        // Redirect with low bits set, with and without stall.
        redir('h103);
        peek("redir103", 'h100, 1);
        idle();
        peek("after_redir", 'h104, 1);
        cycle(1'b1, 1'b1, 'h103, 1'b0, 0, 1'b0, 0, 0);
        peek("redir_stall", 'h100, 1);

        // Random traffic kept to a small region so the predictor gets hits.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 5) == 0, ($urandom % 8) == 0, $urandom_range(0, 'h1FF),
                  ($urandom % 3) == 0,
                  (($urandom % 4) == 0) ? int'($urandom % 8192) : int'($urandom_range(0, 'h1FF)),
                  $urandom % 2, $urandom_range(0, 'h1FF), $urandom % 4);
        end

        // Async reset mid-run wipes the trained predictor.
        cycle(1'b0, 1'b0, 0, 1'b1, 'h010, 1'b1, 'h040, 1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_pc", 32'(pcC), 32'h0);
        check("async_rst_state", 32'(stateC), 32'h1);
        model_reset();
        stall = 1'b1; fail_predict = 1'b0; upd_en = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        redir('h010);
        peek("cold_state", 'h010, 1);
        idle();
        peek("cold_btb", 'h014, 1);

        @(negedge CLK);
        #3;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
